uart_receiver: RTL
==================

Name: uart_receiver

Overview:
- Serial-to-parallel receiver for the 8N1 frames produced by the position-detection UART transmitter: one idle/stop-high line, one start bit (0), 8 data bits LSB first, one stop bit (1).
- Sits on the far end of the serial link, for example in the host-side FPGA or in loopback test benches. It recovers each byte and presents it on a valid/ready output with frame-error and overrun reporting.
- Bit timing comes from a clock-cycle counter on int_clk, matching the transmitter's 9.6 kbaud divider.

Parameters:
- CLKS_PER_BIT, 5210: int_clk cycles per serial bit. 5210 gives 9.6 kbaud at 50 MHz. Must be >= 4.
- HALF_BIT, CLKS_PER_BIT/2: derived and not overridden. Offset from the start edge to the mid-bit sample point.
- CNT_W, 16: width of the bit-timing counter. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- int_clk  in  1  system clock; all logic is on the rising edge
- rst_n  in  1  synchronous active-low reset
- rx  in  1  asynchronous serial input; idles high
- out_data  out  8  received byte; stable while out_valid=1
- out_valid  out  1  byte available; held until accepted
- out_ready  in  1  consumer accepts the byte when out_valid & out_ready
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low
- overrun  out  1  sticky flag: a byte was dropped because out_valid was still held
- ovr_clr  in  1  clears overrun; if a new overrun occurs in the same cycle, set wins
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, counters=0.
  - Both synchronizer flops =1.
  - out_data=0, out_valid=0, frame_err=0, overrun=0, busy=0.
  - Reset mid-frame abandons the frame with no outputs.
- Input synchronizer:
  - rx passes through 2 flops to give rx_s.
  - All decisions use rx_s only, which adds 2 cycles of latency.
- Sample timing:
  - t0 is the first edge at which IDLE sees rx_s=0.
  - Start check at t0+HALF_BIT.
  - Data bit k (k=0..7) sampled at t0+HALF_BIT+(k+1)*CLKS_PER_BIT.
  - Stop bit sampled at t0+HALF_BIT+9*CLKS_PER_BIT (t_stop).
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: on rx_s=0, go to START and clear the counter.
  - START: at the start check:
    - rx_s=0: go to DATA with bit_idx=0.
    - rx_s=1: go to IDLE; treated as a glitch, with no output and no error.
  - DATA: on each sample, shift rx_s into bit[bit_idx] and increment bit_idx. After bit 7, go to STOP.
  - STOP: at t_stop:
    - rx_s=1: deliver the byte and go to IDLE.
    - rx_s=0: frame_err=1 for exactly one cycle, no delivery, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then go to IDLE. A break condition must not generate repeated frames.
- Delivery (effective at edge t_stop+1):
  - If out_valid=0, or out_valid & out_ready in the same cycle:
    - out_data gets the byte and out_valid=1.
  - Otherwise:
    - the byte is dropped, overrun=1, and out_data/out_valid are unchanged.
- Handshake:
  - out_valid falls the edge after out_valid & out_ready, unless a delivery occurs in that same cycle.
  - A simultaneous accept plus delivery keeps out_valid=1 with the new data.
  - out_data never changes while out_valid=1 and out_ready=0.
- Back-to-back frames:
  - A start bit beginning immediately after the stop bit is captured with no lost byte, since IDLE is re-entered at t_stop+1.
  - Minimum frame period is 10*CLKS_PER_BIT.
- Counter:
  - Wraps to 0 at each sample point.
  - No arithmetic overflow is possible, given the CNT_W constraint.

Test Plan:
- Single byte, CLKS_PER_BIT=16, out_ready=1. Send 0xA5 with ideal timing:
  - out_data=0xA5 and out_valid=1 for exactly 1 cycle, beginning at t_stop+1.
  - frame_err=0 and overrun=0 throughout.
- Glitch rejection. Pull rx low for 5 cycles (less than HALF_BIT=8) while in IDLE:
  - busy pulses, then returns to IDLE.
  - No out_valid and no frame_err.
- Framing error. Send 0x3C with the stop bit driven 0 and the line held low for 40 more cycles:
  - frame_err is a single 1-cycle pulse at t_stop+1, with no out_valid.
  - busy stays 1 until rx returns high.
  - A following valid 0x11 is received correctly.
- Backpressure and overrun. With out_ready=0, send 0x12, then 0x34 back-to-back:
  - out_data stays 0x12 with out_valid=1.
  - overrun=1 after the second frame.
  - Asserting out_ready for 1 cycle clears out_valid.
  - Asserting ovr_clr clears overrun.
- Simultaneous accept and deliver. Hold out_valid with 0x55, then assert out_ready exactly at t_stop+1 of the 0xAA frame:
  - out_valid remains 1 with out_data=0xAA, and overrun=0.
- Reset mid-frame. Assert rst_n=0 during data bit 4 of 0xF0:
  - All outputs return to 0 and the state to IDLE.
  - After release, a fresh 0x81 is received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with a two-flop input synchronizer, mid-bit sampling,
// valid/ready byte output, a one-cycle frame error pulse and a sticky overrun flag.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 5210,
    parameter int CNT_W        = 16
) (
    input  logic       int_clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       ovr_clr,
    output logic       busy
);
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t           r_state, w_next;
    logic             r_sync1, r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_stop_seen, r_stop_val;
    logic             w_rx_s, w_sample, w_deliver, w_ferr, w_accept, w_can_take;

    assign w_rx_s     = r_sync2;
    assign w_accept   = out_valid & out_ready;
    assign w_can_take = ~out_valid | out_ready;
    assign busy       = r_state != IDLE;

    always_ff @(posedge int_clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // The stop bit is latched at t_stop; its outcome takes effect one edge later.
    always_comb begin
        w_next    = r_state;
        w_sample  = 1'b0;
        w_deliver = 1'b0;
        w_ferr    = 1'b0;
        case (r_state)
            IDLE:      w_next = w_rx_s ? IDLE : START;
            START: begin
                w_sample = r_cnt == HALF_M1;
                w_next   = w_sample ? (w_rx_s ? IDLE : DATA) : START;
            end
            DATA: begin
                w_sample = r_cnt == BIT_M1;
                w_next   = (w_sample && r_bit_idx == 3'd7) ? STOP : DATA;
            end
            STOP: begin
                w_sample  = ~r_stop_seen && r_cnt == BIT_M1;
                w_deliver = r_stop_seen & r_stop_val;
                w_ferr    = r_stop_seen & ~r_stop_val;
                w_next    = r_stop_seen ? (r_stop_val ? IDLE : WAIT_IDLE) : STOP;
            end
            WAIT_IDLE: w_next = w_rx_s ? IDLE : WAIT_IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge int_clk) begin
        if (!rst_n) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_stop_seen <= 1'b0;
            r_stop_val  <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            r_sync1     <= rx;
            r_sync2     <= r_sync1;
            r_cnt       <= (r_state == IDLE || r_state == WAIT_IDLE || w_sample) ? '0 : r_cnt + CNT_W'(1);
            r_stop_seen <= r_state == STOP && w_sample;
            frame_err   <= w_ferr;
            if (r_state == IDLE) r_bit_idx <= '0;
            if (r_state == DATA && w_sample) begin
                r_shift[r_bit_idx] <= w_rx_s;
                r_bit_idx          <= r_bit_idx + 3'd1;
            end
            if (r_state == STOP && w_sample) r_stop_val <= w_rx_s;
            if (w_deliver && w_can_take) begin
                out_data  <= r_shift;
                out_valid <= 1'b1;
            end else if (w_accept) begin
                out_valid <= 1'b0;
            end
            overrun <= (w_deliver & ~w_can_take) | (overrun & ~ovr_clr);
        end
    end
endmodule
